// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle add/subtract unit processing CHUNK bits per clock.
// The operation is started with start and busy is high while it runs. done
// pulses for one cycle when result and the carry/overflow/zero/neg flags update.
module addsub_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow,
   output logic             zero,
   output logic             neg
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LastCnt = CW'(NCHUNK - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] beff_q, beff_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic             neg_q, neg_d;

   logic [WIDTH-1:0] beff_in;
   logic [CHUNK:0]   csum;

   assign beff_in = op ? ~b : b;

   // Operands shift right one chunk per cycle, so the low chunk is always the live one
   assign csum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, beff_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};

   // Next-state and datapath: latch on accepted start, ripple one chunk per RUN cycle
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      beff_d   = beff_q;
      acc_d    = acc_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
      neg_d    = neg_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               a_d     = a;
               beff_d  = beff_in;
               carry_d = cin;
               a_msb_d = a[WIDTH-1];
               b_msb_d = beff_in[WIDTH-1];
               cnt_d   = '0;
               state_d = StRun;
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            a_d    = a_q >> CHUNK;
            beff_d = beff_q >> CHUNK;
            acc_d  = acc_q >> CHUNK;
            acc_d[WIDTH-1 -: CHUNK] = csum[CHUNK-1:0];
            carry_d = csum[CHUNK];
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LastCnt) begin
               // Final chunk: publish the completed accumulator, never a partial sum
               result_d = acc_d;
               cout_d   = csum[CHUNK];
               ovf_d    = (a_msb_q == b_msb_q) && (acc_d[WIDTH-1] != a_msb_q);
               zero_d   = (acc_d == '0);
               neg_d    = acc_d[WIDTH-1];
               state_d  = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and output flag registers
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         a_q      <= '0;
         beff_q   <= '0;
         acc_q    <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
      end else begin
         a_q      <= a_d;
         beff_q   <= beff_d;
         acc_q    <= acc_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
         neg_q    <= neg_d;
      end
   end

   assign busy     = (state_q == StRun);
   assign done     = (state_q == StDone);
   assign result   = result_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;
   assign zero     = zero_q;
   assign neg      = neg_q;

endmodule
